// File: rtl/ddr_app_pkg.sv
// Shared command encodings and the command-FIFO entry for the app_* responder.
package ddr_app_pkg;

  localparam int unsigned CMD_WIDTH       = 3;
  localparam int unsigned ENTRY_ADDR_BITS = 32;
  localparam int unsigned BEAT_ADDR_SHIFT = 3;

  localparam logic [CMD_WIDTH-1:0] CMD_WRITE = 3'b000;
  localparam logic [CMD_WIDTH-1:0] CMD_READ  = 3'b001;

  // One queued command; addr is zero-extended or truncated to ENTRY_ADDR_BITS.
  typedef struct packed {
    logic [CMD_WIDTH-1:0]       cmd;
    logic [ENTRY_ADDR_BITS-1:0] addr;
  } cmd_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a combinational head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]     store [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 push_ok;
  logic                 pop_ok;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head_c  = store[rd_ptr];

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Entry storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10: begin
          count <= count + CNT_WIDTH'(1);
          full  <= (count == CNT_WIDTH'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - CNT_WIDTH'(1);
          full  <= 1'b0;
          empty <= (count == CNT_WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ddr_app_responder.sv
// BRAM-backed stand-in for the MIG 7-series native app_* interface.
module ddr_app_responder
  import ddr_app_pkg::*;
#(
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned CALIB_CYCLES   = 16,
  parameter int unsigned STALL_PERIOD   = 0,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        app_en,
  input  logic [2:0]                  app_cmd,
  input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
  output logic                        app_rdy,
  input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                        app_wdf_rdy,
  output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        app_rd_data_end,
  output logic                        init_calib_complete
);

  localparam int unsigned MASK_WIDTH       = DDR_DATA_WIDTH / 8;
  localparam int unsigned DATA_ENTRY_WIDTH = DDR_DATA_WIDTH + MASK_WIDTH;
  localparam int unsigned CMD_ENTRY_WIDTH  = $bits(cmd_entry_t);
  localparam int unsigned MEM_DEPTH        = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned CALIB_LAST       = (CALIB_CYCLES == 0) ? 0 : CALIB_CYCLES - 1;
  localparam int unsigned CALIB_CNT_WIDTH  = (CALIB_LAST > 0) ? $clog2(CALIB_LAST + 1) : 1;
  localparam int unsigned STALL_LAST       = (STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1;
  localparam int unsigned STALL_CNT_WIDTH  = (STALL_LAST > 0) ? $clog2(STALL_LAST + 1) : 1;

  logic [CALIB_CNT_WIDTH-1:0]  calib_cnt;
  logic [STALL_CNT_WIDTH-1:0]  stall_cnt;
  logic                        stall_slot;

  cmd_entry_t                  cmd_push_entry;
  cmd_entry_t                  cmd_head;
  logic                        cmd_full;
  logic                        cmd_empty;
  logic                        cmd_accept;
  logic                        cmd_pop;

  logic [DATA_ENTRY_WIDTH-1:0] dat_push_entry;
  logic [DATA_ENTRY_WIDTH-1:0] dat_head;
  logic                        dat_full;
  logic                        dat_empty;
  logic                        dat_accept;
  logic                        dat_pop;

  logic                        cmd_valid;
  logic                        head_is_write;
  logic                        head_is_read;
  logic                        write_go;
  logic                        read_go;
  logic [MEM_DEPTH_LOG2-1:0]   ram_idx;
  logic [DDR_DATA_WIDTH-1:0]   wr_data;
  logic [MASK_WIDTH-1:0]       wr_mask;

  logic [DDR_DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DDR_DATA_WIDTH-1:0]   rd_pipe [RD_LATENCY];
  logic                        rd_vld  [RD_LATENCY];
  logic                        unused_bits;

  // Handshakes seen by the initiator.
  assign app_rdy     = init_calib_complete & ~cmd_full & ~stall_slot;
  assign app_wdf_rdy = init_calib_complete & ~dat_full;
  assign cmd_accept  = app_en & app_rdy;
  assign dat_accept  = app_wdf_wren & app_wdf_rdy;

  // app_wdf_end mirrors app_wdf_wren in 4:1 mode; only the RAM index bits of the address matter.
  assign unused_bits = ^{app_wdf_end, cmd_head.addr};

  assign cmd_push_entry = '{cmd: app_cmd, addr: ENTRY_ADDR_BITS'(app_addr)};
  assign dat_push_entry = {app_wdf_data, app_wdf_mask};

  sync_fifo #(
    .WIDTH (CMD_ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_accept),
    .push_data (cmd_push_entry),
    .pop       (cmd_pop),
    .head_c    (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  sync_fifo #(
    .WIDTH (DATA_ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_dat_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dat_accept),
    .push_data (dat_push_entry),
    .pop       (dat_pop),
    .head_c    (dat_head),
    .full      (dat_full),
    .empty     (dat_empty)
  );

  // In-order execution of the command head; a write head waits for its data beat.
  always_comb begin
    head_is_write = (cmd_head.cmd == CMD_WRITE);
    head_is_read  = (cmd_head.cmd == CMD_READ);
    cmd_valid     = ~cmd_empty & ~rst;
    write_go      = cmd_valid & head_is_write & ~dat_empty;
    read_go       = cmd_valid & head_is_read;
    cmd_pop       = cmd_valid & (~head_is_write | ~dat_empty);
    dat_pop       = write_go;
    ram_idx       = cmd_head.addr[BEAT_ADDR_SHIFT +: MEM_DEPTH_LOG2];
    wr_data       = dat_head[DATA_ENTRY_WIDTH-1:MASK_WIDTH];
    wr_mask       = dat_head[MASK_WIDTH-1:0];
  end

  // Calibration: count out CALIB_CYCLES after reset, then hold ready until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      calib_cnt           <= '0;
      init_calib_complete <= 1'b0;
    end else if (!init_calib_complete) begin
      if (calib_cnt == CALIB_CNT_WIDTH'(CALIB_LAST)) init_calib_complete <= 1'b1;
      else calib_cnt <= calib_cnt + CALIB_CNT_WIDTH'(1);
    end
  end

  // Optional back-pressure: one dead app_rdy cycle after every STALL_PERIOD accepted commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      stall_slot <= 1'b0;
    end else begin
      stall_slot <= 1'b0;
      if (STALL_PERIOD != 0 && cmd_accept) begin
        if (stall_cnt == STALL_CNT_WIDTH'(STALL_LAST)) begin
          stall_cnt  <= '0;
          stall_slot <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
        end
      end
    end
  end

  // RAM write port with per-byte enables; mask bit set means keep the old byte.
  always_ff @(posedge clk) begin
    if (write_go) begin
      for (int b = 0; b < int'(MASK_WIDTH); b++) begin
        if (!wr_mask[b]) mem[ram_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered RAM read followed by the remaining read-latency stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        rd_vld[i]  <= 1'b0;
        rd_pipe[i] <= '0;
      end
    end else begin
      rd_vld[0] <= read_go;
      if (read_go) rd_pipe[0] <= mem[ram_idx];
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign app_rd_data       = rd_pipe[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld[RD_LATENCY-1];

endmodule

// File: tb/tb_ddr_app_responder.sv
// Randomised self-checking bench for ddr_app_responder against a transaction-level memory model.
module tb_ddr_app_responder;
  import ddr_app_pkg::*;

  localparam int unsigned DW     = 128;
  localparam int unsigned AW     = 28;
  localparam int unsigned MW     = DW / 8;
  localparam int unsigned NBEATS = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;

  logic          s_app_en;
  logic [2:0]    s_app_cmd;
  logic [AW-1:0] s_app_addr;
  logic          s_app_rdy;
  logic          s_app_wdf_rdy;
  logic [DW-1:0] s_app_rd_data;
  logic          s_app_rd_data_valid;
  logic          s_app_rd_data_end;
  logic          s_init_calib_complete;

  ddr_app_responder dut (
    .clk (clk), .rst (rst),
    .app_en (app_en), .app_cmd (app_cmd), .app_addr (app_addr), .app_rdy (app_rdy),
    .app_wdf_data (app_wdf_data), .app_wdf_wren (app_wdf_wren), .app_wdf_end (app_wdf_end),
    .app_wdf_mask (app_wdf_mask), .app_wdf_rdy (app_wdf_rdy),
    .app_rd_data (app_rd_data), .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end (app_rd_data_end), .init_calib_complete (init_calib_complete)
  );

  ddr_app_responder #(.STALL_PERIOD(2)) dut_stall (
    .clk (clk), .rst (rst),
    .app_en (s_app_en), .app_cmd (s_app_cmd), .app_addr (s_app_addr), .app_rdy (s_app_rdy),
    .app_wdf_data ('0), .app_wdf_wren (1'b0), .app_wdf_end (1'b0),
    .app_wdf_mask ('0), .app_wdf_rdy (s_app_wdf_rdy),
    .app_rd_data (s_app_rd_data), .app_rd_data_valid (s_app_rd_data_valid),
    .app_rd_data_end (s_app_rd_data_end), .init_calib_complete (s_init_calib_complete)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { logic is_write; logic is_read; int idx; } op_t;
  typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } beat_t;
  typedef struct { logic [DW-1:0] data; logic dend; int cyc; } rx_t;

  op_t           ops[$];
  beat_t         dq[$];
  logic [DW-1:0] exp_q[$];
  rx_t           rx[$];
  logic [DW-1:0] ref_mem [NBEATS];
  bit            written [NBEATS];
  int            written_list[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int last_acc_cyc = 0;
  int s_vld_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every returned beat with the cycle it appeared in.
  always @(negedge clk) begin
    if (app_rd_data_valid === 1'b1) rx.push_back('{data: app_rd_data, dend: app_rd_data_end, cyc: cyc});
    if (s_app_rd_data_valid === 1'b1) s_vld_cnt <= s_vld_cnt + 1;
  end

  // Apply queued commands in acceptance order; a write needs its data beat first.
  function automatic void resolve();
    while (ops.size() > 0) begin
      if (ops[0].is_read) begin
        exp_q.push_back(ref_mem[ops[0].idx]);
        void'(ops.pop_front());
      end else if (ops[0].is_write) begin
        if (dq.size() == 0) break;
        for (int b = 0; b < int'(MW); b++)
          if (!dq[0].mask[b]) ref_mem[ops[0].idx][b*8 +: 8] = dq[0].data[b*8 +: 8];
        if (!written[ops[0].idx]) begin
          written[ops[0].idx] = 1'b1;
          written_list.push_back(ops[0].idx);
        end
        void'(ops.pop_front());
        void'(dq.pop_front());
      end else begin
        void'(ops.pop_front());
      end
    end
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    int guard;
    guard = 0;
    app_en = 1'b1; app_cmd = c; app_addr = a;
    while (app_rdy !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL cmd_accept_timeout: app_rdy never rose for cmd %0d addr %h", c, a);
    end else begin
      last_acc_cyc = cyc;
      ops.push_back('{is_write: (c == CMD_WRITE), is_read: (c == CMD_READ),
                      idx: int'((a >> 3) % NBEATS)});
      resolve();
    end
    @(negedge clk);
    app_en = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d, input logic [MW-1:0] m);
    int guard;
    guard = 0;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    while (app_wdf_rdy !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL data_accept_timeout: app_wdf_rdy never rose");
    end else begin
      dq.push_back('{data: d, mask: m});
      resolve();
    end
    @(negedge clk);
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int g;
    g = 0;
    while (rx.size() < n && g < budget) begin @(negedge clk); g++; end
    ok = (rx.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    app_en = 1'b0; app_cmd = '0; app_addr = '0;
    app_wdf_data = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_mask = '0;
    s_app_en = 1'b0; s_app_cmd = '0; s_app_addr = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (app_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_app_rdy: got %b want 0", app_rdy); end
    n_cmp++; if (app_wdf_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_wdf_rdy: got %b want 0", app_wdf_rdy); end
    n_cmp++; if (app_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", app_rd_data_valid); end
    n_cmp++; if (app_rd_data_end !== 1'b0) begin n_fail++; $display("FAIL reset_rd_end: got %b want 0", app_rd_data_end); end
    n_cmp++; if (app_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", app_rd_data); end
    n_cmp++; if (init_calib_complete !== 1'b0) begin n_fail++; $display("FAIL reset_calib: got %b want 0", init_calib_complete); end
    n_cmp++; if (s_app_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_stall_rdy: got %b want 0", s_app_rdy); end
  endtask

  task automatic test_calib();
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (init_calib_complete !== (k >= 16)) begin
        n_fail++; $display("FAIL calib_cycle_%0d: got %b want %b", k, init_calib_complete, (k >= 16));
      end
      n_cmp++;
      if (app_rdy !== (k >= 16)) begin
        n_fail++; $display("FAIL calib_rdy_cycle_%0d: got %b want %b", k, app_rdy, (k >= 16));
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    rx_t r;
    logic [DW-1:0] e;
    bit ok;
    int t;
    d = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    rx.delete();
    send_data(d, '0);
    send_cmd(CMD_WRITE, 28'h40);
    send_cmd(CMD_READ, 28'h40);
    t = last_acc_cyc;
    wait_rx(1, 30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_rd_timeout: got %0d beats want 1", rx.size()); end
    if (ok) begin
      r = rx.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.data !== e) begin n_fail++; $display("FAIL wr_rd_model: got %h want %h", r.data, e); end
      n_cmp++; if (r.data !== d) begin n_fail++; $display("FAIL wr_rd_value: got %h want %h", r.data, d); end
      n_cmp++; if (r.dend !== 1'b1) begin n_fail++; $display("FAIL wr_rd_end: got %b want 1", r.dend); end
      n_cmp++; if (r.cyc !== t + 5) begin n_fail++; $display("FAIL wr_rd_latency: got %0d want %0d", r.cyc - t, 5); end
    end
    repeat (8) @(negedge clk);
    n_cmp++; if (rx.size() != 0) begin n_fail++; $display("FAIL wr_rd_extra: got %0d extra beats want 0", rx.size()); end
    rx.delete();
  endtask

  task automatic test_masked_write();
    logic [DW-1:0] want;
    rx_t r;
    logic [DW-1:0] e;
    bit ok;
    want = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    rx.delete();
    send_data({DW{1'b1}}, '0);
    send_cmd(CMD_WRITE, 28'h08);
    send_data('0, 16'h00FF);
    send_cmd(CMD_WRITE, 28'h08);
    send_cmd(CMD_READ, 28'h08);
    wait_rx(1, 30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL mask_timeout: got %0d beats want 1", rx.size()); end
    if (ok) begin
      r = rx.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.data !== want) begin n_fail++; $display("FAIL mask_value: got %h want %h", r.data, want); end
      n_cmp++; if (r.data !== e) begin n_fail++; $display("FAIL mask_model: got %h want %h", r.data, e); end
    end
  endtask

  task automatic test_data_before_cmd();
    logic [DW-1:0] d [3];
    rx_t r;
    logic [DW-1:0] e;
    bit ok;
    rx.delete();
    for (int i = 0; i < 3; i++) begin d[i] = rand_beat(); send_data(d[i], '0); end
    for (int i = 0; i < 3; i++) send_cmd(CMD_WRITE, AW'(i * 8));
    for (int i = 0; i < 3; i++) send_cmd(CMD_READ, AW'(i * 8));
    wait_rx(3, 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL dbc_timeout: got %0d beats want 3", rx.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        r = rx.pop_front();
        e = exp_q.pop_front();
        n_cmp++; if (r.data !== d[i]) begin n_fail++; $display("FAIL dbc_value_%0d: got %h want %h", i, r.data, d[i]); end
        n_cmp++; if (r.data !== e) begin n_fail++; $display("FAIL dbc_model_%0d: got %h want %h", i, r.data, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    rx_t r;
    logic [DW-1:0] e;
    bit ok;
    int t0;
    logic [AW-1:0] addrs [4];
    addrs[0] = 28'h0; addrs[1] = 28'h8; addrs[2] = 28'h10; addrs[3] = 28'h40;
    rx.delete();
    for (int i = 0; i < 4; i++) begin
      send_cmd(CMD_READ, addrs[i]);
      if (i == 0) t0 = last_acc_cyc;
    end
    wait_rx(4, 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d beats want 4", rx.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        r = rx.pop_front();
        e = exp_q.pop_front();
        n_cmp++; if (r.data !== e) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", i, r.data, e); end
        n_cmp++; if (r.cyc !== t0 + 5 + i) begin n_fail++; $display("FAIL b2b_cycle_%0d: got %0d want %0d", i, r.cyc - t0, 5 + i); end
      end
    end
  endtask

  task automatic test_random();
    rx_t r;
    logic [DW-1:0] e;
    bit ok;
    int n;
    int sel;
    int idx;
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    rx.delete();
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4 || written_list.size() == 0) begin
        a = AW'($urandom);
        d = rand_beat();
        m = written[int'((a >> 3) % NBEATS)] ? MW'($urandom) : '0;
        if ($urandom_range(0, 1) == 0) begin
          send_data(d, m); send_cmd(CMD_WRITE, a);
        end else begin
          send_cmd(CMD_WRITE, a); send_data(d, m);
        end
      end else if (sel == 4) begin
        send_cmd(3'($urandom_range(2, 7)), AW'($urandom));
      end else begin
        idx = written_list[$urandom_range(0, written_list.size() - 1)];
        a = (AW'($urandom) & ~AW'(28'h1FF8)) | AW'(idx << 3);
        send_cmd(CMD_READ, a);
      end
    end
    n = exp_q.size();
    wait_rx(n, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: got %0d beats want %0d", rx.size(), n); end
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        r = rx.pop_front();
        e = exp_q.pop_front();
        n_cmp++; if (r.data !== e) begin n_fail++; $display("FAIL rand_read_%0d: got %h want %h", i, r.data, e); end
      end
    end
  endtask

  task automatic test_stall();
    int acc;
    int base;
    int g;
    bit stall_next;
    logic exp_rdy;
    acc = 0; stall_next = 1'b0;
    base = s_vld_cnt;
    s_app_cmd = CMD_READ; s_app_addr = '0; s_app_en = 1'b1;
    for (int c = 0; c < 15; c++) begin
      exp_rdy = ~stall_next;
      n_cmp++;
      if (s_app_rdy !== exp_rdy) begin n_fail++; $display("FAIL stall_rdy_cycle_%0d: got %b want %b", c, s_app_rdy, exp_rdy); end
      stall_next = 1'b0;
      if (s_app_rdy === 1'b1) begin
        acc++;
        if (acc % 2 == 0) stall_next = 1'b1;
      end
      @(negedge clk);
    end
    s_app_en = 1'b0;
    n_cmp++; if (acc != 10) begin n_fail++; $display("FAIL stall_accepts: got %0d want 10", acc); end
    g = 0;
    while (s_vld_cnt - base < acc && g < 40) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (s_vld_cnt - base != acc) begin n_fail++; $display("FAIL stall_lost: got %0d beats want %0d", s_vld_cnt - base, acc); end
  endtask

  task automatic test_reset_mid_read();
    rx_t r;
    logic [DW-1:0] e;
    bit ok;
    int g;
    rx.delete();
    send_cmd(CMD_READ, 28'h40);
    @(negedge clk);
    rst = 1'b1;
    ops.delete(); dq.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++; if (rx.size() != 0) begin n_fail++; $display("FAIL rst_inflight: got %0d beats want 0", rx.size()); end
    rx.delete();
    g = 0;
    while (init_calib_complete !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    n_cmp++; if (init_calib_complete !== 1'b1) begin n_fail++; $display("FAIL rst_recal: got %b want 1", init_calib_complete); end
    send_cmd(CMD_READ, 28'h40);
    wait_rx(1, 30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_read_timeout: got %0d beats want 1", rx.size()); end
    if (ok) begin
      r = rx.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (r.data !== e) begin n_fail++; $display("FAIL rst_retained: got %h want %h", r.data, e); end
    end
  endtask

  initial begin
    test_reset();
    test_calib();
    test_write_read();
    test_masked_write();
    test_data_before_cmd();
    test_back_to_back();
    test_random();
    test_stall();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
